// File: rtl/div_unit.sv
// Iterative restoring divider for the execute stage: one quotient bit per cycle,
// signed or unsigned, result packed as {remainder, quotient} for the HI/LO path.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   work;
  logic [WIDTH-1:0]   divisor;
  logic               neg_quo;
  logic               neg_rem;

  logic [2*WIDTH:0]   shifted;
  logic [2*WIDTH:0]   work_next;
  logic [WIDTH+1:0]   trial;
  logic               accept;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1])
      return $unsigned(-v);
    return $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept = (state == FREE) && start_i && !annul_i;
  assign busy_o = (state == BYZERO) || (state == ON);

  // One restoring step: shift, then keep the trial difference if it did not borrow.
  always_comb begin
    shifted   = work << 1;
    trial     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
    work_next = shifted;
    if (!trial[WIDTH+1])
      work_next = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
  end

  // Operand / working datapath registers carry no reset; control qualifies them.
  always_ff @(posedge clk) begin
    if (accept && (opdata2_i != '0)) begin
      work    <= {{(WIDTH+1){1'b0}}, magnitude(opdata1_i, signed_div_i)};
      divisor <= magnitude(opdata2_i, signed_div_i);
      neg_quo <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_rem <= signed_div_i & opdata1_i[WIDTH-1];
    end else if ((state == ON) && !annul_i) begin
      work <= work_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        FREE: begin
          if (accept) begin
            cnt   <= '0;
            state <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {cond_negate(work_next[2*WIDTH-1:WIDTH], neg_rem),
                           cond_negate(work_next[WIDTH-1:0], neg_quo)};
            end
          end
        end
        END: begin
          if (!start_i || annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: WIDTH=32 and WIDTH=8 instances, vector table with a
// result scoreboard plus hand-written annul / reset / divide-by-zero sequences.
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sd32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] r32;
  logic        rdy32, busy32;

  logic        sd8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        rdy8, busy8;

  div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sd32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(r32), .ready_o(rdy32), .busy_o(busy32)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(r8), .ready_o(rdy8), .busy_o(busy8)
  );

  typedef struct {
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_rdy(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction

  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic [63:0] cur_res(input bit w8);
    return w8 ? {48'b0, r8} : r32;
  endfunction

  task automatic drive(input bit w8, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b, input bit start, input bit annul);
    if (w8) begin
      sd8 = sgn; a8 = a[7:0]; b8 = b[7:0]; start8 = start; annul8 = annul;
    end else begin
      sd32 = sgn; a32 = a; b32 = b; start32 = start; annul32 = annul;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          cyc;
    logic [63:0] exp;
    drive(v.w8, v.sgn, v.a, v.b, 1'b1, 1'b0);
    sb_q.push_back(v.exp);
    tick();
    cyc = 1;
    while (!cur_rdy(v.w8) && cyc < 200) begin
      tick();
      cyc++;
    end
    check({v.name, " ready"}, 64'(cur_rdy(v.w8)), 64'd1);
    check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
    exp = sb_q.pop_front();
    check({v.name, " result"}, cur_res(v.w8), exp);
    tick();
    check({v.name, " hold ready"}, 64'(cur_rdy(v.w8)), 64'd1);
    check({v.name, " hold result"}, cur_res(v.w8), exp);
    drive(v.w8, v.sgn, v.a, v.b, 1'b0, 1'b0);
    tick();
    check({v.name, " release ready"}, 64'(cur_rdy(v.w8)), 64'd0);
    check({v.name, " release result"}, cur_res(v.w8), 64'd0);
    check({v.name, " release busy"}, 64'(cur_busy(v.w8)), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    int   cyc;
    vec_t v;

    vecs.push_back('{0, 0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, "u100/7"});
    vecs.push_back('{0, 1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 33, "s-100/7"});
    vecs.push_back('{0, 1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, "sMIN/-1"});
    vecs.push_back('{0, 0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33, "u80000000/FFFFFFFF"});
    vecs.push_back('{0, 1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 33, "s100/-7"});
    vecs.push_back('{0, 1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33, "s-100/-7"});
    vecs.push_back('{0, 0, 32'd5,          32'd9,          64'h00000005_00000000, 33, "u5/9"});
    vecs.push_back('{0, 0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, "uMAX/1"});
    vecs.push_back('{0, 0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33, "uMAX/MAX"});
    vecs.push_back('{0, 0, 32'h12345678,   32'h10,         64'h00000008_01234567, 33, "u12345678/16"});
    vecs.push_back('{0, 1, 32'd7,          32'd0,          64'h0,                 2,  "s7/0"});
    vecs.push_back('{1, 0, 32'd200,        32'd13,         64'h050F,              9,  "w8 u200/13"});
    vecs.push_back('{1, 1, 32'h80,         32'hFF,         64'h0080,              9,  "w8 sMIN/-1"});
    vecs.push_back('{1, 1, 32'hF9,         32'd2,          64'hFFFD,              9,  "w8 s-7/2"});
    vecs.push_back('{1, 0, 32'h80,         32'hFF,         64'h8000,              9,  "w8 u80/FF"});
    vecs.push_back('{1, 0, 32'd0,          32'd5,          64'h0000,              9,  "w8 u0/5"});

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) tick();
    check("reset result", r32, 64'd0);
    check("reset ready", 64'(rdy32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset w8 result", {48'b0, r8}, 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // annul held in FREE blocks acceptance
    drive(1'b0, 1'b0, 32'd9, 32'd9, 1'b1, 1'b1);
    repeat (3) tick();
    check("annul in FREE busy", 64'(busy32), 64'd0);
    check("annul in FREE ready", 64'(rdy32), 64'd0);
    drive(1'b0, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0);
    tick();

    // divide by zero: busy exactly one cycle, ready after E+1
    drive(1'b0, 1'b0, 32'h1234, 32'd0, 1'b1, 1'b0);
    tick();
    check("byzero E busy", 64'(busy32), 64'd1);
    check("byzero E ready", 64'(rdy32), 64'd0);
    tick();
    check("byzero E+1 busy", 64'(busy32), 64'd0);
    check("byzero E+1 ready", 64'(rdy32), 64'd1);
    check("byzero result", r32, 64'd0);
    drive(1'b0, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0);
    tick();

    // annul mid-iteration after edge E+10
    drive(1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b1, 1'b0);
    tick();
    repeat (10) tick();
    check("annul pre busy", 64'(busy32), 64'd1);
    drive(1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b1);
    tick();
    check("annul busy", 64'(busy32), 64'd0);
    check("annul ready", 64'(rdy32), 64'd0);
    check("annul result", r32, 64'd0);
    drive(1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
    seen = 0;
    repeat (40) begin
      tick();
      if (rdy32) seen++;
    end
    check("annul no ready", 64'(seen), 64'd0);
    v = '{0, 0, 32'hFFFFFFFF, 32'd3, 64'h00000000_55555555, 33, "reissue uMAX/3"};
    run_vec(v);

    // synchronous reset while ON at cnt=20
    drive(1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b1, 1'b0);
    tick();
    repeat (20) tick();
    check("rst pre busy", 64'(busy32), 64'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
    tick();
    check("rst mid busy", 64'(busy32), 64'd0);
    check("rst mid ready", 64'(rdy32), 64'd0);
    check("rst mid result", r32, 64'd0);
    rst = 1'b0;
    v = '{0, 0, 32'd9, 32'd9, 64'h00000000_00000001, 33, "after rst u9/9"};
    run_vec(v);

    // annul while in END releases the result with start still held
    drive(1'b0, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    tick();
    cyc = 1;
    while (!rdy32 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("end annul ready", 64'(rdy32), 64'd1);
    check("end annul result", r32, 64'h00000002_0000000E);
    drive(1'b0, 1'b0, 32'd100, 32'd7, 1'b1, 1'b1);
    tick();
    check("end annul drop ready", 64'(rdy32), 64'd0);
    check("end annul drop result", r32, 64'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
